regfile_write_scheduler: RTL and testbench

Owns the single write port of the 16×16 register file and shares it between the writeback stage and the PC-save sequencer used by CALL/INT. A PC save writes the 32-bit PC into two private registers over two consecutive cycles: the high half goes to r10, then the low half to r9. Writeback writes that arrive while the port is reserved are held in a small in-order FIFO, and upstream is stalled when the FIFO cannot absorb more. The block sits between the WB stage and the register file's write_enable/write_addr/write_data inputs.

---
 rtl/regfile_write_scheduler.sv | 135 +++++++++++++
 tb/tb_regfile_write_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register-file write port between writeback and the CALL/INT PC-save sequencer.
// Writebacks arriving while the port is reserved are deferred through a small in-order FIFO.
module regfile_write_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int PC_HI_REG  = 10,
    parameter int PC_LO_REG  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_stall,
    input  logic                  pcsave_req,
    input  logic [31:0]           pc,
    output logic                  pcsave_ack,
    output logic                  pcsave_done,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, SAVE_HI, SAVE_LO} state_t;

    state_t                state;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [31:0]           pc_latch;
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic wb_acc;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

    // A pending save in IDLE must see an empty FIFO, so new writebacks are held off until it drains.
    assign wb_stall = fifo_full | ((state == IDLE) & pcsave_req & ~fifo_empty);
    assign wb_acc   = wb_we & ~wb_stall;

    // An accepted write is deferred whenever the port is busy with a save or with older queued writes.
    assign push = wb_acc & ((state != IDLE) | ~fifo_empty);
    assign pop  = (state == IDLE) & ~fifo_empty;

    // NOTE: storage is not reset; only count/pointers define validity, so stale entries are never issued.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wb_addr;
            fifo_data[wr_ptr] <= wb_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pc_latch    <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            pcsave_ack  <= 1'b0;
            pcsave_done <= 1'b0;
        end else begin
            pcsave_ack  <= 1'b0;
            pcsave_done <= 1'b0;

            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (pcsave_req && fifo_empty) begin
                        pc_latch   <= pc;
                        pcsave_ack <= 1'b1;
                        state      <= SAVE_HI;
                        rf_we      <= wb_acc;
                        rf_waddr   <= wb_addr;
                        rf_wdata   <= wb_data;
                    end else if (!fifo_empty) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= fifo_addr[rd_ptr];
                        rf_wdata <= fifo_data[rd_ptr];
                    end else if (wb_acc) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= wb_addr;
                        rf_wdata <= wb_data;
                    end else begin
                        rf_we <= 1'b0;
                    end
                end
                SAVE_HI: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= ADDR_WIDTH'(PC_HI_REG);
                    rf_wdata <= DATA_WIDTH'(pc_latch[31:16]);
                    state    <= SAVE_LO;
                end
                SAVE_LO: begin
                    rf_we       <= 1'b1;
                    rf_waddr    <= ADDR_WIDTH'(PC_LO_REG);
                    rf_wdata    <= DATA_WIDTH'(pc_latch[15:0]);
                    pcsave_done <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    rf_we <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: expected writes are queued at acceptance
// and compared, in order, against every rf_we cycle.
module tb_regfile_write_scheduler;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic        done;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_stall;
    logic        pcsave_req;
    logic [31:0] pc;
    logic        pcsave_ack;
    logic        pcsave_done;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;

    int          tests = 0;
    int          fails = 0;
    wr_t         sb[$];
    logic [15:0] shadow [16];

    regfile_write_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_stall   (wb_stall),
        .pcsave_req (pcsave_req),
        .pc         (pc),
        .pcsave_ack (pcsave_ack),
        .pcsave_done(pcsave_done),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [15:0] d, input logic dn);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.done = dn;
        sb.push_back(e);
    endtask

    // Drives a writeback, checks stall against the bench expectation, queues it if it should be taken.
    task automatic drive_wb(input logic we, input logic [3:0] a, input logic [15:0] d,
                            input logic exp_stall, input string tag);
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
        #1;
        check({tag, "_stall"}, {31'd0, wb_stall}, {31'd0, exp_stall});
        if (we && !exp_stall) push_exp(a, d, 1'b0);
    endtask

    task automatic do_save(input logic [31:0] p, input int exp_lat, input string tag);
        int lat;
        logic got_ack;
        pcsave_req = 1'b1;
        pc         = p;
        lat        = 0;
        got_ack    = 1'b0;
        for (int i = 0; i < 8 && !got_ack; i++) begin
            tick();
            lat++;
            got_ack = pcsave_ack;
        end
        check({tag, "_ack_seen"}, {31'd0, got_ack}, 32'd1);
        check({tag, "_ack_lat"}, lat, exp_lat);
        if (got_ack) begin
            push_exp(4'd10, p[31:16], 1'b0);
            push_exp(4'd9, p[15:0], 1'b1);
        end
        pcsave_req = 1'b0;
    endtask

    // Scoreboard monitor: every port write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst) begin
            if (rf_we) begin
                if (sb.size() == 0) begin
                    check("spurious_wr", {31'd0, rf_we}, 32'd0);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", {28'd0, rf_waddr}, {28'd0, e.addr});
                    check("wr_data", {16'd0, rf_wdata}, {16'd0, e.data});
                    check("wr_done", {31'd0, pcsave_done}, {31'd0, e.done});
                end
                shadow[rf_waddr] = rf_wdata;
            end else if (pcsave_done) begin
                check("done_no_wr", {31'd0, pcsave_done}, 32'd0);
            end
        end
    end

    initial begin
        rst        = 1'b0;
        wb_we      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        pcsave_req = 1'b0;
        pc         = '0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {28'd0, rf_waddr}, 32'd0);
        check("rst_wdata", {16'd0, rf_wdata}, 32'd0);
        check("rst_ack", {31'd0, pcsave_ack}, 32'd0);
        check("rst_done", {31'd0, pcsave_done}, 32'd0);
        check("rst_stall", {31'd0, wb_stall}, 32'd0);
        rst = 1'b1;

        // Direct writeback latency
        drive_wb(1'b1, 4'd3, 16'h1234, 1'b0, "t1a");
        tick();
        check("t1_we", {31'd0, rf_we}, 32'd1);
        check("t1_addr", {28'd0, rf_waddr}, 32'd3);
        check("t1_data", {16'd0, rf_wdata}, 32'h1234);
        drive_wb(1'b0, 4'd0, 16'h0, 1'b0, "t1b");
        tick();
        check("t1_we_off", {31'd0, rf_we}, 32'd0);

        // Idle PC save
        do_save(32'hABCD_0010, 1, "t2");
        check("t2_we_ack", {31'd0, rf_we}, 32'd0);
        tick();
        check("t2_ack_pulse", {31'd0, pcsave_ack}, 32'd0);
        repeat (3) tick();

        // Save with back-to-back writebacks; the fourth write is held while the FIFO is full
        pcsave_req = 1'b1;
        pc         = 32'h1234_5678;
        drive_wb(1'b1, 4'd1, 16'h0001, 1'b0, "t3a");
        tick();
        check("t3_ack", {31'd0, pcsave_ack}, 32'd1);
        push_exp(4'd10, 16'h1234, 1'b0);
        push_exp(4'd9, 16'h5678, 1'b1);
        pcsave_req = 1'b0;
        drive_wb(1'b1, 4'd2, 16'h0002, 1'b0, "t3b");
        tick();
        drive_wb(1'b1, 4'd3, 16'h0003, 1'b0, "t3c");
        tick();
        drive_wb(1'b1, 4'd4, 16'h0004, 1'b1, "t3d");
        tick();
        drive_wb(1'b1, 4'd4, 16'h0004, 1'b0, "t3e");
        tick();
        drive_wb(1'b0, 4'd0, 16'h0, 1'b0, "t3f");
        repeat (3) tick();

        // Request while the FIFO holds one entry: stall, drain, then ack
        pcsave_req = 1'b1;
        pc         = 32'h0BAD_F00D;
        drive_wb(1'b0, 4'd0, 16'h0, 1'b0, "t4a");
        tick();
        check("t4_ack1", {31'd0, pcsave_ack}, 32'd1);
        push_exp(4'd10, 16'h0BAD, 1'b0);
        push_exp(4'd9, 16'hF00D, 1'b1);
        pcsave_req = 1'b0;
        drive_wb(1'b1, 4'd5, 16'h0005, 1'b0, "t4b");
        tick();
        drive_wb(1'b0, 4'd0, 16'h0, 1'b0, "t4c");
        tick();
        pcsave_req = 1'b1;
        pc         = 32'h1357_2468;
        drive_wb(1'b1, 4'd6, 16'h0006, 1'b1, "t4d");
        tick();
        check("t4_ack_early", {31'd0, pcsave_ack}, 32'd0);
        drive_wb(1'b1, 4'd6, 16'h0006, 1'b0, "t4e");
        tick();
        check("t4_ack2", {31'd0, pcsave_ack}, 32'd1);
        push_exp(4'd10, 16'h1357, 1'b0);
        push_exp(4'd9, 16'h2468, 1'b1);
        pcsave_req = 1'b0;
        drive_wb(1'b0, 4'd0, 16'h0, 1'b0, "t4f");
        repeat (3) tick();

        // Writeback to r9 during SAVE_HI lands after the PC-low write
        wb_we = 1'b0;
        do_save(32'h1111_2222, 1, "t5");
        drive_wb(1'b1, 4'd9, 16'h5555, 1'b0, "t5b");
        tick();
        drive_wb(1'b0, 4'd0, 16'h0, 1'b0, "t5c");
        repeat (4) tick();
        check("t5_r9_final", {16'd0, shadow[9]}, 32'h5555);

        // Asynchronous reset in SAVE_HI abandons the save
        do_save(32'h2222_3333, 1, "t6");
        #2 rst = 1'b0;
        #1;
        check("t6_rf_we", {31'd0, rf_we}, 32'd0);
        check("t6_waddr", {28'd0, rf_waddr}, 32'd0);
        check("t6_wdata", {16'd0, rf_wdata}, 32'd0);
        check("t6_ack", {31'd0, pcsave_ack}, 32'd0);
        check("t6_done", {31'd0, pcsave_done}, 32'd0);
        check("t6_stall", {31'd0, wb_stall}, 32'd0);
        sb.delete();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        do_save(32'h4444_5555, 1, "t6b");
        repeat (3) tick();

        // Back-to-back direct writes with random data
        for (int i = 0; i < 8; i++) begin
            drive_wb(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 1'b0, "rnd");
            tick();
        end
        drive_wb(1'b0, 4'd0, 16'h0, 1'b0, "rnd_end");
        repeat (3) tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
